// File: rtl/jtag_tap_sequencer.sv
// JTAG master: divides clk_i into TCK and walks the 1149.1 TAP through reset,
// IR/DR scans or idle clocks, one command at a time, returning captured TDO.
module jtag_tap_sequencer #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [6:0]         cmd_len_i,
  input  logic [MAX_LEN-1:0] cmd_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [MAX_LEN-1:0] rsp_data_o,
  output logic               busy_o,
  output logic               tck_o,
  output logic               tms_o,
  output logic               td_o,
  input  logic               td_i
);

  typedef enum logic [2:0] {IDLE, HEAD, SHIFT, TAIL, RSP} state_t;

  localparam int             CW        = $clog2(2 * CLK_DIV) > 0 ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  SAMPLE    = CW'(CLK_DIV);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(2 * CLK_DIV - 1);
  localparam logic [6:0]     LEN_MAX   = 7'(MAX_LEN);

  state_t             state;
  logic [1:0]         op;
  logic [6:0]         len;
  logic [6:0]         shift_left;
  logic [6:0]         seq_left;
  logic [5:0]         seq_tms;
  logic [CW-1:0]      cnt;
  logic [MAX_LEN-1:0] tdi_sr;
  logic [MAX_LEN-1:0] cap;
  logic [MAX_LEN-1:0] cap_nxt;
  logic [6:0]         scan_len;
  logic [7:0]         shamt;
  logic               bit_end;
  logic               is_scan;

  assign cmd_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign bit_end     = (cnt == BIT_LAST);
  assign is_scan     = op[0] ^ op[1];
  assign shamt       = 8'(MAX_LEN) - {1'b0, len};

  always_comb begin
    scan_len = cmd_len_i;
    if (cmd_len_i == '0)
      scan_len = 7'd1;
    else if (cmd_len_i > LEN_MAX)
      scan_len = LEN_MAX;
  end

  // TDO enters from the MSB side on the first high-phase cycle of each shift bit
  always_comb begin
    cap_nxt = cap;
    if (state == SHIFT && cnt == SAMPLE)
      cap_nxt = {td_i, cap[MAX_LEN-1:1]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      op          <= '0;
      len         <= '0;
      shift_left  <= '0;
      seq_left    <= '0;
      seq_tms     <= '0;
      cnt         <= '0;
      tdi_sr      <= '0;
      cap         <= '0;
      tck_o       <= 1'b0;
      tms_o       <= 1'b1;
      td_o        <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            op         <= cmd_op_i;
            len        <= scan_len;
            tdi_sr     <= cmd_data_i;
            cap        <= '0;
            cnt        <= '0;
            tck_o      <= 1'b0;
            td_o       <= 1'b0;
            rsp_data_o <= '0;
            state      <= HEAD;
            // head TMS patterns are stored LSB-first
            case (cmd_op_i)
              2'b00: begin seq_tms <= 6'b011111; seq_left <= 7'd6; tms_o <= 1'b1; end
              2'b01: begin seq_tms <= 6'b000011; seq_left <= 7'd4; tms_o <= 1'b1; end
              2'b10: begin seq_tms <= 6'b000001; seq_left <= 7'd3; tms_o <= 1'b1; end
              default: begin
                seq_tms  <= '0;
                seq_left <= cmd_len_i;
                tms_o    <= 1'b0;
                if (cmd_len_i == '0) begin
                  state       <= RSP;
                  rsp_valid_o <= 1'b1;
                end
              end
            endcase
          end
        end

        HEAD, SHIFT, TAIL: begin
          cap <= cap_nxt;
          if (!bit_end) begin
            cnt   <= cnt + 1'b1;
            tck_o <= (cnt >= HALF_LAST);
          end else begin
            cnt   <= '0;
            tck_o <= 1'b0;
            if (state == SHIFT) begin
              if (shift_left != '0) begin
                shift_left <= shift_left - 1'b1;
                tms_o      <= (shift_left == 7'd1);
                td_o       <= tdi_sr[0];
                tdi_sr     <= {1'b0, tdi_sr[MAX_LEN-1:1]};
              end else begin
                // tail (Exit1 -> Update -> Idle) reuses the head sequencer
                state    <= TAIL;
                seq_tms  <= 6'b000001;
                seq_left <= 7'd2;
                tms_o    <= 1'b1;
                td_o     <= 1'b0;
              end
            end else if (seq_left > 7'd1) begin
              seq_left <= seq_left - 1'b1;
              seq_tms  <= {1'b0, seq_tms[5:1]};
              tms_o    <= seq_tms[1];
              td_o     <= 1'b0;
            end else if (state == HEAD && is_scan) begin
              state      <= SHIFT;
              shift_left <= len - 1'b1;
              tms_o      <= (len == 7'd1);
              td_o       <= tdi_sr[0];
              tdi_sr     <= {1'b0, tdi_sr[MAX_LEN-1:1]};
            end else begin
              state       <= RSP;
              rsp_valid_o <= 1'b1;
              tms_o       <= 1'b0;
              td_o        <= 1'b0;
              if (state == TAIL)
                rsp_data_o <= cap >> shamt;
            end
          end
        end

        RSP: begin
          tck_o <= 1'b0;
          tms_o <= 1'b0;
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_tap_sequencer.sv
// Scoreboard bench for jtag_tap_sequencer: directed commands push expected
// responses; a negedge monitor checks TMS/TDI per TCK, timing and response data.
module tb_jtag_tap_sequencer;
  localparam int CLK_DIV = 2;
  localparam int MAX_LEN = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [6:0]         cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy;
  logic               tck;
  logic               tms;
  logic               tdo_pin;
  logic               tdi_pin;
  int                 td_mode;   // 0 tie low, 1 tie high, 2 loopback

  assign tdi_pin = (td_mode == 2) ? tdo_pin : (td_mode == 1);

  jtag_tap_sequencer #(.CLK_DIV(CLK_DIV), .MAX_LEN(MAX_LEN)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_len_i(cmd_len), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .busy_o(busy), .tck_o(tck), .tms_o(tms), .td_o(tdo_pin), .td_i(tdi_pin)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           n;
    logic [63:0]  rsp;
    logic [127:0] tms;
    logic [127:0] tdi;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] op, input int len, input logic [63:0] d,
                              input logic [63:0] rsp, input int n);
    exp_t e;
    int p;
    int l;
    e.n = n; e.rsp = rsp; e.tms = '0; e.tdi = '0;
    case (op)
      2'b00: for (int i = 0; i < 5; i++) e.tms[i] = 1'b1;
      2'b11: ;
      default: begin
        l = (len == 0) ? 1 : (len > 64) ? 64 : len;
        e.tms[0] = 1'b1; p = 1;
        if (op == 2'b01) begin e.tms[1] = 1'b1; p = 2; end
        p += 2;
        for (int i = 0; i < l; i++) begin
          e.tdi[p] = d[i];
          e.tms[p] = (i == l - 1);
          p++;
        end
        e.tms[p] = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Monitor state
  int           acc_edge = 0;
  int           n_tck = 0;
  int           rsp_cnt = 0;
  int           last_hs_edge = 0;
  int           last_gap = 0;
  logic [127:0] tms_seen = '0;
  logic [127:0] tdi_seen = '0;
  logic         prev_tck = 1'b0;
  logic         prev_rv = 1'b0;
  logic [63:0]  hold = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_tck = 1'b0;
        prev_rv  = 1'b0;
      end else begin
        if (cmd_valid && cmd_ready) begin
          acc_edge = cyc + 1;
          last_gap = acc_edge - last_hs_edge;
          n_tck = 0; tms_seen = '0; tdi_seen = '0;
        end
        if (tck && !prev_tck) begin
          if (n_tck < 128) begin
            tms_seen[n_tck] = tms;
            tdi_seen[n_tck] = tdo_pin;
          end
          n_tck++;
        end
        if (rsp_valid && !prev_rv) begin
          hold = rsp_data;
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp actual=%0h required=none", rsp_data);
          end else
            check("rsp_cycle", cyc, acc_edge + 2 * CLK_DIV * sb[0].n);
        end
        if (rsp_valid) begin
          if (!rsp_ready) begin
            check("hold_data", rsp_data, hold);
            check("hold_tck", tck, 0);
            check("hold_tms", tms, 0);
            check("hold_cmd_ready", cmd_ready, 0);
          end else begin
            last_hs_edge = cyc + 1;
            if (sb.size() > 0) begin
              e = sb.pop_front();
              check("rsp_data", rsp_data, e.rsp);
              check("tck_count", n_tck, e.n);
              check("tms_seq", tms_seen, e.tms);
              check("tdi_seq", tdi_seen, e.tdi);
              rsp_cnt++;
            end
          end
        end
        prev_tck = tck;
        prev_rv  = rsp_valid;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] op, input int len, input logic [63:0] d,
                       input logic [63:0] rsp, input int n);
    int t;
    sb.push_back(mk(op, len, d, rsp, n));
    tick();
    cmd_valid = 1'b1; cmd_op = op; cmd_len = 7'(len); cmd_data = d;
    t = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      if (++t > 2000) begin
        checks++; errors++;
        $display("FAIL accept_timeout actual=not_ready required=ready");
        break;
      end
    end
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_len   = 7'($urandom);
    cmd_data  = {$urandom, $urandom};
  endtask

  task automatic wait_rsp(input int target);
    int t;
    t = 0;
    while (rsp_cnt < target) begin
      @(negedge clk);
      if (++t > 5000) begin
        checks++; errors++;
        $display("FAIL rsp_timeout actual=%0d required=%0d", rsp_cnt, target);
        break;
      end
    end
  endtask

  initial begin
    int t;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_data = '0;
    rsp_ready = 1'b1; td_mode = 0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_tck", tck, 0);
    check("rst_tms", tms, 1);
    check("rst_td", tdo_pin, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_busy", busy, 0);
    tick();
    rst = 1'b0;

    // TAP reset, IR, DR, clamping, idle, mask of bits above len
    td_mode = 0; offer(2'b00, 0, 64'h0, 64'h0, 6); wait_rsp(1);
    td_mode = 2; offer(2'b01, 5, 64'h01, 64'h01, 11); wait_rsp(2);
    td_mode = 1; offer(2'b10, 32, 64'hDEADBEEF, 64'h0000_0000_FFFF_FFFF, 37); wait_rsp(3);
    td_mode = 1; offer(2'b10, 0, 64'h2, 64'h1, 6); wait_rsp(4);
    td_mode = 2; offer(2'b10, 100, 64'hA5A5_0F0F_1234_8001, 64'hA5A5_0F0F_1234_8001, 69); wait_rsp(5);
    td_mode = 1; offer(2'b11, 0, 64'hFFFF, 64'h0, 0); wait_rsp(6);
    td_mode = 1; offer(2'b11, 3, 64'hFFFF, 64'h0, 3); wait_rsp(7);
    td_mode = 2; offer(2'b10, 8, 64'hFFFF_FFFF_FFFF_FFC3, 64'hC3, 13); wait_rsp(8);

    // Backpressure with a second command offered during the wait
    tick(); rsp_ready = 1'b0;
    offer(2'b10, 16, 64'h1234, 64'h1234, 21);
    t = 0;
    while (!rsp_valid && t < 2000) begin @(negedge clk); t++; end
    check("bp_rsp_seen", rsp_valid, 1);
    sb.push_back(mk(2'b11, 0, 64'h0, 64'h0, 0));
    tick();
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_len = 7'd0; cmd_data = '0;
    repeat (10) tick();
    rsp_ready = 1'b1;
    t = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      if (++t > 100) begin
        checks++; errors++;
        $display("FAIL bp_accept_timeout actual=not_ready required=ready");
        break;
      end
    end
    tick();
    cmd_valid = 1'b0;
    wait_rsp(10);
    check("b2b_gap", last_gap, 1);

    // Reset during the 10th shift bit of a 32-bit DR scan (13th TCK)
    td_mode = 2;
    offer(2'b10, 32, 64'hCAFE_F00D, 64'hCAFE_F00D, 37);
    t = 0;
    while (n_tck < 13 && t < 2000) begin @(negedge clk); t++; end
    check("mid_scan_reached", (n_tck >= 13), 1);
    tick();
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_tck", tck, 0);
    check("abort_tms", tms, 1);
    check("abort_td", tdo_pin, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    td_mode = 0;
    offer(2'b00, 0, 64'h0, 64'h0, 6);
    wait_rsp(11);

    repeat (5) tick();
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jtag_tap_sequencer.md
Name: jtag_tap_sequencer

Overview:
- On-chip JTAG master that drives the debug TAP of the cv32e40p FPGA top (tck/tms/td pins) from a simple command/response interface.
- Accepts one TAP operation at a time: TAP reset, IR scan, DR scan or idle clocks. Generates TCK by dividing the system clock, sequences TMS through the IEEE 1149.1 state machine, shifts TDI out and captures TDO.
- Sits between a bring-up controller or host bridge and the core's JTAG debug transport; it replaces bench-driven pin wiggling.

Parameters:
- CLK_DIV, 4: TCK half-period in clk_i cycles (≥1).
- MAX_LEN, 64: maximum scan length in bits; also the width of the data and response buses.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-high
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_op_i  in  2  00 TAP reset, 01 IR scan, 10 DR scan, 11 idle clocks
- cmd_len_i  in  7  scan bit count / idle TCK count
- cmd_data_i  in  MAX_LEN  TDI data, LSB shifted first
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_data_o  out  MAX_LEN  captured TDO, first bit in bit 0, right-aligned
- busy_o  out  1  command in progress or response pending
- tck_o  out  1  JTAG TCK to DUT
- tms_o  out  1  JTAG TMS
- td_o  out  1  JTAG TDI to DUT
- td_i  in  1  JTAG TDO from DUT

Behaviour:
- Reset values: tck_o=0, tms_o=1, td_o=0, cmd_ready_o=1, rsp_valid_o=0, rsp_data_o=0, busy_o=0. The FSM goes to IDLE and the divider counter is cleared.
- A reset asserted mid-operation aborts the operation. There is no partial response. Outputs take their reset values in the cycle after rst_i is sampled high.
- FSM states: IDLE -> HEAD -> SHIFT -> TAIL -> RSP -> IDLE. TAP reset and idle-clock ops use HEAD only, then go to RSP.
- cmd_ready_o=1 only in IDLE. The accept cycle is cycle 0.
- One TCK bit = low phase of CLK_DIV cycles, then high phase of CLK_DIV cycles. The first low phase starts at cycle 1.
- tms_o and td_o update on the first cycle of each low phase.
- td_i is sampled on the first cycle of each high phase, i.e. the tck_o rising edge.
- tck_o is a registered output with no glitches. It is 0 in IDLE and RSP.
- TMS sequences, all starting and ending in Run-Test/Idle:
  - TAP reset: 1,1,1,1,1,0 (6 TCK).
  - IR scan: head 1,1,0,0; then len shift bits with TMS=0 except the last bit, which has TMS=1; tail 1,0. Total 6+len TCK.
  - DR scan: head 1,0,0; shift as for IR; tail 1,0. Total 5+len TCK.
  - Idle: len TCK with TMS=0. len=0 gives zero TCK and goes straight to RSP.
- Length rules for scans: len=0 is treated as 1; len>MAX_LEN is clamped to MAX_LEN.
- td_o carries cmd_data bit i during shift bit i. td_o=0 during head and tail.
- Captured TDO shifts in from the MSB side and is right-aligned at completion. Bits at len and above read 0.
- TAP reset and idle ops return rsp_data_o=0.
- Response timing: rsp_valid_o rises at cycle 1+N·2·CLK_DIV, where N is the total TCK count.
- rsp_valid_o and rsp_data_o are held stable until rsp_ready_i=1. The FSM then returns to IDLE on the next cycle, so back-to-back commands have a minimum 1-cycle gap.
- While waiting in RSP: tck_o=0 and tms_o=0 are held.
- busy_o = (state != IDLE).
- cmd_* inputs are ignored when cmd_ready_o=0. Data is latched on accept, so input changes during an operation have no effect.

Test Plan:
- CLK_DIV=2, rsp_ready_i=1, TAP reset -> TMS sampled at tck rising edges reads 1,1,1,1,1,0; rsp_valid_o rises at cycle 25; rsp_data_o=0; tck_o period is 4 clk cycles.
- IR scan, len=5, data=5'h01, td_i looped back from td_o -> TMS sequence 1,1,0,0,0,0,0,0,1,1,0; TDI shift bits 1,0,0,0,0; rsp_data_o=0x01 at cycle 45.
- DR scan, len=32, data=0xDEADBEEF, td_i tied to 1 -> rsp_data_o=0x00000000_FFFFFFFF; TDI bits in order equal 0xDEADBEEF, LSB first; 37 TCK.
- Clamping: DR scan len=0 -> exactly 1 shift bit (6 TCK); len=100 -> 64 shift bits.
- Idle op: len=0 -> rsp_valid_o at cycle 1, no tck_o edges; len=3 -> 3 TCK with TMS=0.
- Backpressure: hold rsp_ready_i=0 for 10 cycles after a DR scan completes -> rsp_data_o stable, cmd_ready_o=0, tck_o=0. A new command offered in this window is not accepted until one cycle after the handshake.
- Reset mid-scan: assert rst_i for 1 cycle during the 10th shift bit of a 32-bit DR scan -> next cycle tck_o=0, tms_o=1, td_o=0, rsp_valid_o=0, cmd_ready_o=1. A following TAP reset command completes normally.
